// File: rtl/laser_cover_counter.sv
// laser_cover_counter
//
// Target buffer and coverage-count engine for the LASER center search.
// After reset it captures NUM_PTS target points. For each candidate center
// it then evaluates PAR targets per cycle, counts the targets that lie
// within the laser radius, and builds a per-target hit bitmap.
//
// Optional feature macro: LASER_EXCL_EN
//   When defined, the excl_mask input exists. Excluded targets are never
//   counted and never reported in cov_mask. The mask is captured with start
//   and held for the whole count.
//
// Ports:
//   CLK        clock; all logic on the rising edge
//   RST        synchronous active-low reset
//   X, Y       target coordinates (unsigned 0..15), qualified by in_valid
//   in_valid   X/Y hold a target this cycle (ignored once load_done is set)
//   load_done  all NUM_PTS targets stored; held until reset
//   start      request a count for cx/cy (accepted in READY and DONE only)
//   cx, cy     candidate center coordinates (unsigned 0..15)
//   busy       count in progress
//   cnt_valid  one-cycle pulse; cnt and cov_mask are final
//   cnt        number of hits, 0..NUM_PTS
//   cov_mask   bit i set when target i is hit
//   excl_mask  (LASER_EXCL_EN only) bit i set means target i is never counted
//   dbg_state  current FSM state: 0 LOAD, 1 READY, 2 COUNT, 3 DONE
//
// Handshake: start is a single-cycle request sampled on a rising edge; it is
// taken only when the engine is in READY or DONE. busy rises after the edge
// that accepts start and falls in the cnt_valid cycle. cnt/cov_mask change
// only in the cnt_valid cycle and hold their values otherwise.

module laser_cover_counter #(
  parameter int NUM_PTS   = 40,
  parameter int PAR       = 4,
  parameter int RADIUS_SQ = 16
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [3:0]                       X,
  input  logic [3:0]                       Y,
  input  logic                             in_valid,
  output logic                             load_done,
  input  logic                             start,
  input  logic [3:0]                       cx,
  input  logic [3:0]                       cy,
  output logic                             busy,
  output logic                             cnt_valid,
  output logic [$clog2(NUM_PTS+1)-1:0]     cnt,
  output logic [NUM_PTS-1:0]               cov_mask,
`ifdef LASER_EXCL_EN
  input  logic [NUM_PTS-1:0]               excl_mask,
`endif
  output logic [1:0]                       dbg_state
);

  localparam int NB = NUM_PTS / PAR;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;
  localparam int CW = $clog2(NUM_PTS + 1);

  localparam logic [8:0]    R9     = 9'(RADIUS_SQ);
  localparam logic [PW-1:0] LAST_P = PW'(NUM_PTS - 1);
  localparam logic [BW-1:0] LAST_B = BW'(NB - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_READY = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   wr_ptr;
  logic [BW-1:0]   bidx;
  logic [3:0]      cx_r;
  logic [3:0]      cy_r;
  logic [CW-1:0]   acc;
  logic [NUM_PTS-1:0] mask_acc;
`ifdef LASER_EXCL_EN
  logic [NUM_PTS-1:0] excl_r;
`endif

  // Target storage: contents are don't-care after reset, so no reset here.
  logic [3:0] buf_x [NUM_PTS];
  logic [3:0] buf_y [NUM_PTS];

  // Per-batch evaluation scratch
  logic [PW-1:0]      ti;
  logic [3:0]         tx, ty;
  logic [4:0]         dx, dy, ndx, ndy;
  logic [3:0]         adx, ady;
  logic [7:0]         sqx, sqy;
  logic [8:0]         dsum;
  logic               hit;
  logic [CW-1:0]      batch_hits;
  logic [NUM_PTS-1:0] batch_mask;
  logic [CW-1:0]      acc_next;
  logic [NUM_PTS-1:0] mask_next;

  assign dbg_state = state;

  // Evaluate targets bidx*PAR .. bidx*PAR+PAR-1 against the latched center.
  // Differences are formed on zero-extended 5-bit operands; the magnitude is
  // taken explicitly so a negative offset can never square as a large value.
  always_comb begin
    ti         = '0;
    tx         = '0;
    ty         = '0;
    dx         = '0;
    dy         = '0;
    ndx        = '0;
    ndy        = '0;
    adx        = '0;
    ady        = '0;
    sqx        = '0;
    sqy        = '0;
    dsum       = '0;
    hit        = 1'b0;
    batch_hits = '0;
    batch_mask = '0;
    for (int p = 0; p < PAR; p++) begin
      ti   = PW'(PW'(bidx) * PW'(PAR)) + PW'(p);
      tx   = buf_x[ti];
      ty   = buf_y[ti];
      dx   = {1'b0, tx} - {1'b0, cx_r};
      dy   = {1'b0, ty} - {1'b0, cy_r};
      ndx  = 5'd0 - dx;
      ndy  = 5'd0 - dy;
      adx  = dx[4] ? ndx[3:0] : dx[3:0];
      ady  = dy[4] ? ndy[3:0] : dy[3:0];
      sqx  = {4'd0, adx} * {4'd0, adx};
      sqy  = {4'd0, ady} * {4'd0, ady};
      dsum = {1'b0, sqx} + {1'b0, sqy};
      hit  = (dsum <= R9);
`ifdef LASER_EXCL_EN
      hit  = hit & ~excl_r[ti];
`endif
      batch_mask[ti] = hit;
      batch_hits     = batch_hits + CW'(hit);
    end
    acc_next  = acc + batch_hits;
    mask_next = mask_acc | batch_mask;
  end

  always_ff @(posedge CLK) begin
    if (RST && state == S_LOAD && in_valid) begin
      buf_x[wr_ptr] <= X;
      buf_y[wr_ptr] <= Y;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_LOAD;
      wr_ptr    <= '0;
      bidx      <= '0;
      cx_r      <= '0;
      cy_r      <= '0;
      acc       <= '0;
      mask_acc  <= '0;
      load_done <= 1'b0;
      busy      <= 1'b0;
      cnt_valid <= 1'b0;
      cnt       <= '0;
      cov_mask  <= '0;
`ifdef LASER_EXCL_EN
      excl_r    <= '0;
`endif
    end else begin
      cnt_valid <= 1'b0;
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_P) begin
              state     <= S_READY;
              load_done <= 1'b1;
            end
          end
        end
        // DONE behaves like READY for start so counts can run back-to-back.
        S_READY, S_DONE: begin
          if (start) begin
            cx_r     <= cx;
            cy_r     <= cy;
            bidx     <= '0;
            acc      <= '0;
            mask_acc <= '0;
            busy     <= 1'b1;
            state    <= S_COUNT;
`ifdef LASER_EXCL_EN
            excl_r   <= excl_mask;
`endif
          end else begin
            state <= S_READY;
          end
        end
        S_COUNT: begin
          acc      <= acc_next;
          mask_acc <= mask_next;
          if (bidx == LAST_B) begin
            // Last batch: publish the totals including this batch.
            state     <= S_DONE;
            busy      <= 1'b0;
            cnt_valid <= 1'b1;
            cnt       <= acc_next;
            cov_mask  <= mask_next;
          end else begin
            bidx <= bidx + 1'b1;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_cover_counter.sv
// tb_laser_cover_counter
//
// Self-checking bench for laser_cover_counter (default parameters).
// Compiles with or without LASER_EXCL_EN.

module tb_laser_cover_counter;

  localparam int N = 40;
  localparam int R = 16;
`ifdef LASER_EXCL_EN
  localparam bit USE_EXCL = 1'b1;
`else
  localparam bit USE_EXCL = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [3:0]   X = '0;
  logic [3:0]   Y = '0;
  logic         in_valid = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   cx = '0;
  logic [3:0]   cy = '0;
  logic         load_done;
  logic         busy;
  logic         cnt_valid;
  logic [5:0]   cnt;
  logic [N-1:0] cov_mask;
  logic [1:0]   dbg_state;
`ifdef LASER_EXCL_EN
  logic [N-1:0] excl_mask = '0;
`endif

  always #5 CLK = ~CLK;

  laser_cover_counter dut (
    .CLK       (CLK),
    .RST       (RST),
    .X         (X),
    .Y         (Y),
    .in_valid  (in_valid),
    .load_done (load_done),
    .start     (start),
    .cx        (cx),
    .cy        (cy),
    .busy      (busy),
    .cnt_valid (cnt_valid),
    .cnt       (cnt),
    .cov_mask  (cov_mask),
`ifdef LASER_EXCL_EN
    .excl_mask (excl_mask),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int           errors = 0;
  int           checks = 0;
  int           px [N];
  int           py [N];
  logic [5:0]   exp_q [$];
  logic [N-1:0] exp_mask_q [$];
  logic [5:0]   last_cnt;
  logic [N-1:0] last_mask;

  typedef struct {
    logic [3:0]   vcx;
    logic [3:0]   vcy;
    logic [5:0]   exp_cnt;
    logic [N-1:0] exp_mask;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: count targets with (x-cx)^2 + (y-cy)^2 <= R using plain integers.
  function automatic void model(input int mcx, input int mcy, input logic [N-1:0] ex,
                                output int c, output logic [N-1:0] m);
    c = 0;
    m = '0;
    for (int i = 0; i < N; i++) begin
      int ddx = px[i] - mcx;
      int ddy = py[i] - mcy;
      if ((ddx * ddx + ddy * ddy) <= R && !(USE_EXCL && ex[i])) begin
        c++;
        m[i] = 1'b1;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic one_edge_reset();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cnt_valid"}, cnt_valid, 0);
    check({tag, "_cnt"}, cnt, 0);
    check({tag, "_cov_mask"}, cov_mask, 0);
    check({tag, "_state_load"}, dbg_state, 2'd0);
  endtask

  // mode 0: all at (8,8); mode 1: boundary pattern; mode 2: random
  task automatic load_frame(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: begin px[i] = 8; py[i] = 8; end
        1: begin
          case (i)
            0: begin px[i] = 12; py[i] = 8; end
            1: begin px[i] = 4;  py[i] = 8; end
            2: begin px[i] = 12; py[i] = 9; end
            3: begin px[i] = 0;  py[i] = 0; end
            default: begin px[i] = 15; py[i] = 15; end
          endcase
        end
        default: begin px[i] = $urandom_range(0, 15); py[i] = $urandom_range(0, 15); end
      endcase
    end
    for (int i = 0; i < N; i++) begin
      @(negedge CLK);
      if (i == N - 1) check("load_done_before_last", load_done, 0);
      X = 4'(px[i]);
      Y = 4'(py[i]);
      in_valid = 1'b1;
    end
    @(negedge CLK);
    in_valid = 1'b0;
    check("load_done_after_last", load_done, 1);
  endtask

  // Pulse start for one edge; returns at the first negedge after that edge.
  task automatic start_pulse(input logic [3:0] a, input logic [3:0] b, input logic [N-1:0] ex);
    @(negedge CLK);
    cx = a;
    cy = b;
`ifdef LASER_EXCL_EN
    excl_mask = ex;
`endif
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
`ifdef LASER_EXCL_EN
    excl_mask = ~ex;  // must have been captured with start
`endif
    if (ex === 'x) check("unreachable_x", 0, 1);
  endtask

  // Waits for cnt_valid; lat0 = cycles already elapsed since start sampling.
  task automatic wait_result(input int lat0, input string tag);
    int lat = lat0;
    while (cnt_valid !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    if (cnt_valid !== 1'b1) begin
      check({tag, "_timeout"}, 0, 1);
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(exp_mask_q.pop_front());
      end
      return;
    end
    check({tag, "_latency"}, lat, 11);
    check({tag, "_busy_low"}, busy, 0);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 0, 1);
      return;
    end
    last_cnt  = exp_q.pop_front();
    last_mask = exp_mask_q.pop_front();
    check({tag, "_cnt"}, cnt, last_cnt);
    check({tag, "_cov_mask"}, cov_mask, last_mask);
  endtask

  task automatic run_vec(input logic [3:0] a, input logic [3:0] b, input logic [N-1:0] ex,
                         input logic [5:0] ec, input logic [N-1:0] em, input string tag);
    exp_q.push_back(ec);
    exp_mask_q.push_back(em);
    start_pulse(a, b, ex);
    check({tag, "_busy_high"}, busy, 1);
    wait_result(1, tag);
  endtask

  task automatic push_model(input logic [3:0] a, input logic [3:0] b, input logic [N-1:0] ex);
    int c;
    logic [N-1:0] m;
    model(int'(a), int'(b), ex, c, m);
    exp_q.push_back(6'(c));
    exp_mask_q.push_back(m);
  endtask

  task automatic do_count(input logic [3:0] a, input logic [3:0] b, input logic [N-1:0] ex,
                          input string tag);
    push_model(a, b, ex);
    start_pulse(a, b, ex);
    check({tag, "_busy_high"}, busy, 1);
    wait_result(1, tag);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int rises;
    logic [63:0] rnd;
    logic [N-1:0] ex;

    tbl[0] = '{4'd8,  4'd8,  6'd2,  40'h00_0000_0003};
    tbl[1] = '{4'd15, 4'd15, 6'd36, 40'hFF_FFFF_FFF0};
    tbl[2] = '{4'd12, 4'd8,  6'd2,  40'h00_0000_0005};
    tbl[3] = '{4'd0,  4'd0,  6'd1,  40'h00_0000_0008};
    tbl[4] = '{4'd4,  4'd8,  6'd1,  40'h00_0000_0002};
    tbl[5] = '{4'd12, 4'd12, 6'd2,  40'h00_0000_0005};

    // Reset state
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b1;

    // start during LOAD is ignored
    start_pulse(4'd8, 4'd8, '0);
    check("start_in_load_busy", busy, 0);
    @(negedge CLK);
    check("start_in_load_state", dbg_state, 2'd0);
    check("start_in_load_valid", cnt_valid, 0);

    // All targets at (8,8)
    load_frame(0);

    // A 41st point must not overwrite target 0
    @(negedge CLK);
    X = 4'd0;
    Y = 4'd0;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    check("extra_point_load_done", load_done, 1);

    run_vec(4'd8, 4'd8, '0, 6'd40, {N{1'b1}}, "all_hit");

`ifdef LASER_EXCL_EN
    run_vec(4'd8, 4'd8, 40'h00_0000_03FF, 6'd30, 40'hFF_FFFF_FC00, "excl");
    check("excl_low_bits", cov_mask[9:0], 0);
`endif

    // Boundary pattern, table-driven
    one_edge_reset();
    check_reset_outputs("reload");
    load_frame(1);
    for (int v = 0; v < 6; v++)
      run_vec(tbl[v].vcx, tbl[v].vcy, '0, tbl[v].exp_cnt, tbl[v].exp_mask, $sformatf("tbl%0d", v));

    // start while busy is ignored
    push_model(4'd8, 4'd8, '0);
    start_pulse(4'd8, 4'd8, '0);
    @(negedge CLK);
    @(negedge CLK);
    cx = 4'd15;
    cy = 4'd15;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_result(4, "busy_start");
    rises = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (cnt_valid === 1'b1 || busy === 1'b1) rises++;
    end
    check("busy_start_no_second", rises, 0);
    check("busy_start_hold", cnt, last_cnt);

    // start in the cnt_valid cycle: back-to-back
    push_model(4'd15, 4'd15, '0);
    start_pulse(4'd15, 4'd15, '0);
    wait_result(1, "b2b_first");
    push_model(4'd12, 4'd12, '0);
    cx = 4'd12;
    cy = 4'd12;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("b2b_busy", busy, 1);
    wait_result(1, "b2b_second");

    // Reset in the middle of a count
    start_pulse(4'd8, 4'd8, '0);
    repeat (3) @(negedge CLK);
    check("midcount_busy", busy, 1);
    one_edge_reset();
    check_reset_outputs("midcount");

    // Random frame and centers
    load_frame(2);
    for (int k = 0; k < 20; k++) begin
      rnd = {$urandom, $urandom};
      ex  = USE_EXCL ? rnd[N-1:0] : '0;
      if (k > 0) begin
        repeat ($urandom_range(0, 3)) @(negedge CLK);
        check("rand_hold_cnt", cnt, last_cnt);
        check("rand_hold_mask", cov_mask, last_mask);
      end
      if (k % 3 == 0)
        do_count(4'(px[k]), 4'(py[k]), ex, $sformatf("rand%0d", k));
      else
        do_count(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ex, $sformatf("rand%0d", k));
    end

    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/laser_cover_counter.md
# laser_cover_counter

Target buffer and coverage-count engine feeding the LASER center-search controller. It captures the target points streamed in after reset, then, for each candidate laser center the search FSM issues, it counts the targets within the laser radius and produces a per-target hit bitmap. All signed-distance arithmetic for the search lives here, so the controller only compares counts.

## Interface
- `NUM_PTS`, 40: targets per frame; must be divisible by `PAR`.
- `PAR`, 4: targets evaluated per cycle.
- `RADIUS_SQ`, 16: hit if dx²+dy² ≤ `RADIUS_SQ`; 0..450.
- `CLK` in 1: clock; all logic on the rising edge.
- `RST` in 1: synchronous, active-low reset.
- `X` in 4: target x, unsigned 0..15.
- `Y` in 4: target y, unsigned 0..15.
- `in_valid` in 1: `X`/`Y` hold a target this cycle.
- `load_done` out 1: all `NUM_PTS` targets stored.
- `start` in 1: request a count for `cx`/`cy`.
- `cx` in 4: candidate center x, unsigned.
- `cy` in 4: candidate center y, unsigned.
- `busy` out 1: count in progress.
- `cnt_valid` out 1: one-cycle pulse; `cnt` and `cov_mask` are final.
- `cnt` out 6: number of hits, 0..`NUM_PTS`.
- `cov_mask` out `NUM_PTS`: bit i = target i hit.
- `excl_mask` in `NUM_PTS`: only with `LASER_EXCL_EN`. Bit i set means target i is never counted.

## Operation
States:
- **LOAD**: entered on reset.
  - Each `in_valid` cycle stores `X`/`Y` at `wr_ptr`, then increments `wr_ptr`.
  - When the `NUM_PTS`-th point is stored, go to READY and set `load_done`=1 (held until reset).
- **READY**: `start`=1 latches `cx`/`cy`, sets `busy`=1, clears the internal index and accumulator, and goes to COUNT.
- **COUNT**: each cycle evaluates targets idx..idx+`PAR`-1 and adds their hits to the accumulator.
  - After the last batch, go to DONE.
- **DONE**: one cycle.
  - `cnt_valid`=1; `cnt` and `cov_mask` are updated in the same cycle.
  - `busy`=0; return to READY.

Arithmetic:
- dx = {1'b0,X} − {1'b0,cx}, as a signed 5-bit value (−15..15); dy likewise.
- Zero-extend before subtracting. Mixing unsigned 4-bit operands with signed or unsized literals is forbidden: a negative dx must never be treated as a large positive.
- dx² and dy² are 8-bit unsigned; their sum is 9-bit unsigned.
- Compare with ≤; a sum exactly equal to `RADIUS_SQ` is a hit.

Boundary rules:
- `in_valid` after `load_done` is ignored; index 0 is never overwritten.
- `start` is ignored in LOAD and while `busy`.
- `start` in the DONE cycle is accepted: `cnt_valid` pulses and a new count begins back-to-back.
- `cnt` and `cov_mask` hold their last values until the next DONE.

Reset (any state, including mid-COUNT):
- Return to LOAD; `wr_ptr`=0.
- All outputs go to 0 (`load_done`, `busy`, `cnt_valid`, `cnt`, `cov_mask`).
- Buffer contents are don't-care.

## Timing
- `start` sampled at edge k:
  - `busy`=1 from after edge k.
  - Batch j is accumulated at edge k+1+j.
  - `cnt_valid` is high in the cycle after edge k+`NUM_PTS`/`PAR` (11 cycles after `start` with the defaults).
- `load_done` rises in the cycle after the edge that stores the final point.
- `busy` is low in the `cnt_valid` cycle.

## Configuration
- `LASER_EXCL_EN` defined:
  - The `excl_mask` port exists.
  - Target i counts only if hit && !`excl_mask`[i].
  - `cov_mask` also reports hit && !`excl_mask`[i].
  - `excl_mask` is sampled with `start` and held for the whole count.
  - The controller uses this to score the second laser against targets the first laser has not already covered.
- Not defined:
  - No `excl_mask` port.
  - Every hit counts.

## Test plan
- Load 40 targets all at (8,8); `start` with (8,8) → `cnt_valid` exactly 11 cycles after `start`, `cnt`=40, `cov_mask`=all ones.
- Radius boundary, center (8,8): targets (12,8) and (4,8) (dx = ±4, sum 16) hit; (12,9) (sum 17) misses; (0,0) misses.
  - Center (15,15) with target (0,0): dx=−15, sum 450 → miss, with no wrap to a small positive value.
- Protocol:
  - `start` during LOAD → no `busy`.
  - `start` while `busy` → ignored; `cnt` reflects the first center.
  - `start` in the `cnt_valid` cycle → second `cnt_valid` 11 cycles later.
  - A 41st `in_valid` with (0,0) → target 0 is unchanged.
- With `LASER_EXCL_EN`: all targets at (8,8), `excl_mask` bits 0..9 set, center (8,8) → `cnt`=30, `cov_mask`[9:0]=0.
- `RST`=0 held low for one clock edge during COUNT → all outputs 0, state LOAD.
  - After reloading 40 new points, a count completes correctly.
